// File: rtl/hdmi_packet_pkg.sv
// Shared constants, types and the BCH LFSR step for the data island packet serializer.
package hdmi_packet_pkg;

  localparam int unsigned PACKET_PIXELS    = 32;
  localparam int unsigned HEADER_DATA_BITS = 24;
  localparam int unsigned SUB_DATA_BITS    = 56;
  localparam logic [7:0]  BCH_POLY         = 8'h83;

  typedef logic [23:0] packet_header_t;
  typedef logic [55:0] packet_sub_t;

  // One reflected-LFSR step: shift right, fold the polynomial in on feedback.
  function automatic logic [7:0] bch_step(input logic [7:0] ecc, input logic data_bit,
                                          input logic [7:0] poly = BCH_POLY);
    logic fb;
    fb = ecc[0] ^ data_bit;
    return (ecc >> 1) ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/bch_ecc_lane.sv
// 8-bit BCH parity accumulator absorbing 1 or 2 bits per enabled cycle.
module bch_ecc_lane
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter logic [7:0]  POLY           = BCH_POLY
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic       seed,
  input  logic       enable,
  input  logic [1:0] data_bits,
  output logic [7:0] ecc
);

  logic [7:0] ecc_q;
  logic [7:0] ecc_d;
  logic [7:0] ecc_base;

  // Seeding discards the previous packet's parity before absorbing the first bit.
  always_comb begin
    ecc_base = seed ? 8'h00 : ecc_q;
    ecc_d    = bch_step(ecc_base, data_bits[0], POLY);
    if (BITS_PER_CYCLE == 2) begin
      ecc_d = bch_step(ecc_d, data_bits[1], POLY);
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      ecc_q <= 8'h00;
    end else if (enable) begin
      ecc_q <= ecc_d;
    end
  end

  assign ecc = ecc_q;

endmodule

// File: rtl/data_island_packet_serializer.sv
// Serializes header/subpackets into 9 bits per pixel with on-the-fly BCH parity.
// Define HDMI_PACKET_CAPTURE_EN to latch header/sub at pixel 0 into shadow registers.
module data_island_packet_serializer
  import hdmi_packet_pkg::*;
#(
  parameter logic [7:0] ECC_POLY = BCH_POLY
) (
  input  logic        clk_pixel,
  input  logic        reset_n,
  input  logic        data_island_period,
  input  logic        data_island_next,
  input  logic [23:0] header,
  input  logic [55:0] sub [3:0],
  output logic [4:0]  packet_pixel_counter,
  output logic        packet_enable,
  output logic [8:0]  packet_data,
  output logic        packet_valid
);

  logic [4:0]     counter_q;
  logic           first_pixel;
  logic           hdr_data_phase;
  logic           sub_data_phase;
  packet_header_t hdr_cur;
  packet_sub_t    sub_cur [4];
  logic           hdr_bit;
  logic [7:0]     hdr_ecc;
  logic [7:0]     sub_ecc [4];
  logic [3:0]     sub_even;
  logic [3:0]     sub_odd;
  logic [8:0]     packet_data_d;
  logic [8:0]     packet_data_q;
  logic           packet_valid_q;

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      counter_q <= 5'd0;
    end else if (data_island_period) begin
      counter_q <= counter_q + 5'd1;
    end else begin
      counter_q <= 5'd0;
    end
  end

  assign first_pixel    = (counter_q == 5'd0);
  assign hdr_data_phase = (counter_q < 5'(HEADER_DATA_BITS));
  assign sub_data_phase = (counter_q < 5'(SUB_DATA_BITS / 2));
  assign packet_enable  = data_island_next &&
                          (!data_island_period || counter_q == 5'(PACKET_PIXELS - 1));

`ifdef HDMI_PACKET_CAPTURE_EN
  packet_header_t hdr_shadow_q;
  packet_sub_t    sub_shadow_q [4];

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      hdr_shadow_q <= '0;
      for (int i = 0; i < 4; i++) sub_shadow_q[i] <= '0;
    end else if (data_island_period && first_pixel) begin
      hdr_shadow_q <= header;
      for (int i = 0; i < 4; i++) sub_shadow_q[i] <= sub[i];
    end
  end

  // Pixel 0 must use the live inputs since the shadow loads on that same edge.
  always_comb begin
    hdr_cur = first_pixel ? header : hdr_shadow_q;
    for (int i = 0; i < 4; i++) sub_cur[i] = first_pixel ? sub[i] : sub_shadow_q[i];
  end
`else
  always_comb begin
    hdr_cur = header;
    for (int i = 0; i < 4; i++) sub_cur[i] = sub[i];
  end
`endif

  // Parity phase indices: c-24 and 2(c-28) reduce to the low counter bits.
  always_comb begin
    hdr_bit = hdr_data_phase ? hdr_cur[counter_q] : hdr_ecc[counter_q[2:0]];
    for (int i = 0; i < 4; i++) begin
      if (sub_data_phase) begin
        sub_even[i] = sub_cur[i][{counter_q, 1'b0}];
        sub_odd[i]  = sub_cur[i][{counter_q, 1'b1}];
      end else begin
        sub_even[i] = sub_ecc[i][{counter_q[1:0], 1'b0}];
        sub_odd[i]  = sub_ecc[i][{counter_q[1:0], 1'b1}];
      end
    end
  end

  bch_ecc_lane #(
    .BITS_PER_CYCLE(1),
    .POLY          (ECC_POLY)
  ) u_hdr_lane (
    .clk_pixel(clk_pixel),
    .reset_n  (reset_n),
    .seed     (first_pixel),
    .enable   (data_island_period && hdr_data_phase),
    .data_bits({1'b0, hdr_bit}),
    .ecc      (hdr_ecc)
  );

  for (genvar i = 0; i < 4; i++) begin : g_sub_lane
    bch_ecc_lane #(
      .BITS_PER_CYCLE(2),
      .POLY          (ECC_POLY)
    ) u_sub_lane (
      .clk_pixel(clk_pixel),
      .reset_n  (reset_n),
      .seed     (first_pixel),
      .enable   (data_island_period && sub_data_phase),
      .data_bits({sub_odd[i], sub_even[i]}),
      .ecc      (sub_ecc[i])
    );
  end

  always_comb begin
    packet_data_d = 9'h000;
    if (data_island_period) begin
      packet_data_d = {sub_odd, sub_even, hdr_bit};
    end
  end

  always_ff @(posedge clk_pixel or negedge reset_n) begin
    if (!reset_n) begin
      packet_data_q  <= 9'h000;
      packet_valid_q <= 1'b0;
    end else begin
      packet_data_q  <= packet_data_d;
      packet_valid_q <= data_island_period;
    end
  end

  assign packet_pixel_counter = counter_q;
  assign packet_data          = packet_data_q;
  assign packet_valid         = packet_valid_q;

endmodule

// File: tb/tb_data_island_packet_serializer.sv
// Directed bench for the data island packet serializer with hand-computed BCH values.
module tb_data_island_packet_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        period;
  logic        next_pix;
  logic [23:0] header;
  logic [55:0] sub [3:0];
  logic [4:0]  cnt;
  logic        en;
  logic [8:0]  pd;
  logic        pv;

  int unsigned vectors = 0;
  int unsigned fails   = 0;

  logic [8:0] exp_null [32];
  logic [8:0] exp_h    [32];
  logic [8:0] exp_a    [32];
  logic [8:0] exp_cur  [32];

  always #5 clk = ~clk;

  data_island_packet_serializer dut (
    .clk_pixel           (clk),
    .reset_n             (reset_n),
    .data_island_period  (period),
    .data_island_next    (next_pix),
    .header              (header),
    .sub                 (sub),
    .packet_pixel_counter(cnt),
    .packet_enable       (en),
    .packet_data         (pd),
    .packet_valid        (pv)
  );

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    vectors++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sub(input logic [55:0] v0, input logic [55:0] v1,
                         input logic [55:0] v2, input logic [55:0] v3);
    sub[0] = v0;
    sub[1] = v1;
    sub[2] = v2;
    sub[3] = v3;
  endtask

  task automatic pre_enable(input string tag);
    period   = 1'b0;
    next_pix = 1'b1;
    #1;
    chk($sformatf("%s_pre_enable", tag), 9'(en), 9'h001);
    tick();
  endtask

  // Runs 32 pixels against exp_cur; chain keeps data_island_next high at pixel 31.
  task automatic send_packet(input string tag, input bit chain);
    for (int c = 0; c < 32; c++) begin
      chk($sformatf("%s_cnt%0d", tag, c), 9'(cnt), 9'(c));
      period   = 1'b1;
      next_pix = (c < 31) ? 1'b1 : chain;
      #1;
      if (c == 31) chk($sformatf("%s_enable_c31", tag), 9'(en), 9'(chain));
      else if (c == 12) chk($sformatf("%s_enable_mid", tag), 9'(en), 9'h000);
      tick();
      chk($sformatf("%s_data%0d", tag, c), pd, exp_cur[c]);
      chk($sformatf("%s_valid%0d", tag, c), 9'(pv), 9'h001);
    end
  endtask

  task automatic idle_check(input string tag);
    period   = 1'b0;
    next_pix = 1'b0;
    tick();
    chk($sformatf("%s_idle_valid", tag), 9'(pv), 9'h000);
    chk($sformatf("%s_idle_data", tag), pd, 9'h000);
    chk($sformatf("%s_idle_cnt", tag), 9'(cnt), 9'h000);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      exp_null[i] = 9'h000;
      exp_h[i]    = 9'h000;
      exp_a[i]    = 9'h000;
    end
    // header=1: header ECC 8'h4A emitted LSB first over pixels 24..31.
    exp_h[0]  = 9'h001;
    exp_h[25] = 9'h001;
    exp_h[27] = 9'h001;
    exp_h[30] = 9'h001;
    // header=1 plus sub[2]=1: sub[2] ECC 8'hBF on bits 3 (even) and 7 (odd).
    exp_a[0]  = 9'h009;
    exp_a[25] = 9'h001;
    exp_a[27] = 9'h001;
    exp_a[28] = 9'h088;
    exp_a[29] = 9'h088;
    exp_a[30] = 9'h089;
    exp_a[31] = 9'h080;

    reset_n  = 1'b0;
    period   = 1'b0;
    next_pix = 1'b0;
    header   = 24'h0;
    set_sub(56'h0, 56'h0, 56'h0, 56'h0);
    #2;
    chk("reset_data", pd, 9'h000);
    chk("reset_valid", 9'(pv), 9'h000);
    chk("reset_cnt", 9'(cnt), 9'h000);
    chk("reset_enable", 9'(en), 9'h000);
    tick();
    tick();
    #2;
    reset_n = 1'b1;
    tick();

    // Null packet.
    exp_cur = exp_null;
    pre_enable("null");
    chk("null_valid_before", 9'(pv), 9'h000);
    send_packet("null", 1'b0);
    idle_check("null");

    // Single header bit.
    header  = 24'h000001;
    exp_cur = exp_h;
    pre_enable("hdr1");
    send_packet("hdr1", 1'b0);
    idle_check("hdr1");

    // Back-to-back packets.
    set_sub(56'h0, 56'h0, 56'h1, 56'h0);
    exp_cur = exp_a;
    pre_enable("b2b");
    send_packet("b2b_p1", 1'b1);
    send_packet("b2b_p2", 1'b0);
    idle_check("b2b");

    // Abort at pixel 10 with all-ones content, then a clean packet.
    header = 24'hFFFFFF;
    set_sub('1, '1, '1, '1);
    pre_enable("abort");
    for (int c = 0; c < 10; c++) begin
      period   = 1'b1;
      next_pix = 1'b1;
      tick();
      chk($sformatf("abort_data%0d", c), pd, 9'h1FF);
    end
    chk("abort_cnt10", 9'(cnt), 9'd10);
    period   = 1'b0;
    next_pix = 1'b0;
    tick();
    chk("abort_cnt_cleared", 9'(cnt), 9'h000);
    chk("abort_valid", 9'(pv), 9'h000);
    chk("abort_data", pd, 9'h000);
    header = 24'h000001;
    set_sub(56'h0, 56'h0, 56'h1, 56'h0);
    pre_enable("after_abort");
    send_packet("after_abort", 1'b0);
    idle_check("after_abort");

    // Reset while counter is 15.
    header = 24'hFFFFFF;
    set_sub('1, '1, '1, '1);
    pre_enable("rst");
    for (int c = 0; c < 15; c++) begin
      period   = 1'b1;
      next_pix = 1'b1;
      tick();
    end
    chk("rst_cnt15", 9'(cnt), 9'd15);
    chk("rst_data_before", pd, 9'h1FF);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_async_data", pd, 9'h000);
    chk("rst_async_valid", 9'(pv), 9'h000);
    chk("rst_async_cnt", 9'(cnt), 9'h000);
    period   = 1'b0;
    next_pix = 1'b0;
    tick();
    #2;
    reset_n = 1'b1;
    tick();
    header = 24'h000001;
    set_sub(56'h0, 56'h0, 56'h1, 56'h0);
    pre_enable("after_rst");
    send_packet("after_rst", 1'b0);
    idle_check("after_rst");

    // sub[0] changes while the counter is 5.
    header = 24'h0;
    set_sub(56'h0, 56'h0, 56'h0, 56'h0);
    pre_enable("chg");
    for (int c = 0; c < 28; c++) begin
      logic [8:0] want;
      if (c == 5) sub[0] = '1;
      period   = 1'b1;
      next_pix = 1'b1;
      tick();
`ifdef HDMI_PACKET_CAPTURE_EN
      want = 9'h000;
`else
      want = (c >= 5) ? 9'h022 : 9'h000;
`endif
      chk($sformatf("chg_data%0d", c), pd, want);
    end
    idle_check("chg");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
